// File: rtl/fft_pkg.sv
// Shared types for the 8-point FFT datapath: component width, complex sample
// struct and the butterfly engine state encoding.
package fft_pkg;

    localparam int FFT_WIDTH = 32;

    typedef struct packed {
        logic signed [FFT_WIDTH-1:0] re;
        logic signed [FFT_WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fft_state_t;

endpackage

// File: rtl/radix2_butterfly.sv
// Combinational radix-2 butterfly: sum = a + b, diff = a - b, modulo 2^FFT_WIDTH.
import fft_pkg::*;

module radix2_butterfly (
    input  cplx_t a,
    input  cplx_t b,
    output cplx_t sum,
    output cplx_t diff
);

    // Component-wise add/subtract; results wrap with no growth bit.
    always_comb begin
        sum.re  = a.re + b.re;
        sum.im  = a.im + b.im;
        diff.re = a.re - b.re;
        diff.im = a.im - b.im;
    end

endmodule

// File: rtl/fft_8.sv
// Butterfly engine: captures two complex samples on start, registers their
// sum and difference one edge later and flags them with a one-cycle done pulse.
import fft_pkg::*;

module fft_8 #(
    parameter int WIDTH = FFT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    done,
    input  logic signed [WIDTH-1:0] x0_re,
    input  logic signed [WIDTH-1:0] x0_im,
    input  logic signed [WIDTH-1:0] x1_re,
    input  logic signed [WIDTH-1:0] x1_im,
    output logic signed [WIDTH-1:0] X0_re,
    output logic signed [WIDTH-1:0] X0_im,
    output logic signed [WIDTH-1:0] X1_re,
    output logic signed [WIDTH-1:0] X1_im
);

    fft_state_t state;
    cplx_t      cap_a;
    cplx_t      cap_b;
    cplx_t      bf_sum;
    cplx_t      bf_diff;

    radix2_butterfly u_bf (
        .a    (cap_a),
        .b    (cap_b),
        .sum  (bf_sum),
        .diff (bf_diff)
    );

    // Sequencer with capture and output registers; start is only honoured in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
            cap_a <= '0;
            cap_b <= '0;
            X0_re <= '0;
            X0_im <= '0;
            X1_re <= '0;
            X1_im <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cap_a <= '{re: x0_re, im: x0_im};
                        cap_b <= '{re: x1_re, im: x1_im};
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    X0_re <= bf_sum.re;
                    X0_im <= bf_sum.im;
                    X1_re <= bf_diff.re;
                    X1_im <= bf_diff.im;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_8.sv
// Scoreboard bench for fft_8: stimulus pushes hand-computed results, a negedge
// monitor pops and compares them whenever done is high.
import fft_pkg::*;

module tb_fft_8;

    localparam int W = FFT_WIDTH;

    typedef struct {
        logic [W-1:0] r0;
        logic [W-1:0] i0;
        logic [W-1:0] r1;
        logic [W-1:0] i1;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic done;
    logic signed [W-1:0] x0_re, x0_im, x1_re, x1_im;
    logic signed [W-1:0] X0_re, X0_im, X1_re, X1_im;

    exp_t exp_q[$];
    int   done_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   e0;

    fft_8 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .done  (done),
        .x0_re (x0_re),
        .x0_im (x0_im),
        .x1_re (x1_re),
        .x1_im (x1_im),
        .X0_re (X0_re),
        .X0_im (X0_im),
        .X1_re (X1_re),
        .X1_im (X1_im)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_outs(input string name, input exp_t e);
        check({name, "_X0_re"}, X0_re, e.r0);
        check({name, "_X0_im"}, X0_im, e.i0);
        check({name, "_X1_re"}, X1_re, e.r1);
        check({name, "_X1_im"}, X1_im, e.i1);
    endtask

    function automatic exp_t mk(input int r0, input int i0, input int r1, input int i1);
        exp_t e;
        e.r0 = r0; e.i0 = i0; e.r1 = r1; e.i1 = i1;
        return e;
    endfunction

    // Monitor: every done cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            done_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                check_outs("sb", exp_q.pop_front());
            end
        end
    end

    task automatic set_in(input int a, input int b, input int c, input int d);
        x0_re = a; x0_im = b; x1_re = c; x1_im = d;
    endtask

    // One-cycle start pulse; e0 is the cycle number of the sampling edge.
    task automatic pulse(input int a, input int b, input int c, input int d);
        @(negedge clk);
        set_in(a, b, c, d);
        start = 1'b1;
        @(negedge clk);
        e0 = cyc;
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        check({name, "_pending"}, W'(exp_q.size()), '0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        set_in(0, 0, 0, 0);
        #2;
        check("rst_done", W'(done), '0);
        check_outs("rst", mk(0, 0, 0, 0));
        repeat (2) @(negedge clk);
        check("rst_done_clk", W'(done), '0);
        rst = 1'b0;

        // Basic, with latency and stability after done.
        done_cyc.delete();
        exp_q.push_back(mk(14, 2, 6, 4));
        pulse(10, 3, 4, -1);
        set_in(-7, -7, -7, -7);
        drain("basic");
        repeat (3) @(negedge clk);
        check("basic_count", W'(done_cyc.size()), W'(1));
        if (done_cyc.size() > 0) check("basic_lat", W'(done_cyc[0]), W'(e0 + 1));
        check_outs("basic_hold", mk(14, 2, 6, 4));

        // Wrap-around arithmetic.
        done_cyc.delete();
        exp_q.push_back(mk(32'h80000000, 32'h80000001, 32'h7FFFFFFE, 32'h7FFFFFFF));
        pulse(32'h7FFFFFFF, 32'h80000000, 1, 1);
        drain("wrap");
        check("wrap_count", W'(done_cyc.size()), W'(1));
        if (done_cyc.size() > 0) check("wrap_lat", W'(done_cyc[0]), W'(e0 + 1));

        // Start while busy is ignored; result uses first inputs.
        done_cyc.delete();
        exp_q.push_back(mk(70, -30, 130, -70));
        @(negedge clk);
        set_in(100, -50, -30, 20);
        start = 1'b1;
        @(negedge clk);
        set_in(1, 2, 3, 4);
        @(negedge clk);
        start = 1'b0;
        drain("busy");
        repeat (4) @(negedge clk);
        check("busy_count", W'(done_cyc.size()), W'(1));

        // Held start: one operation every three cycles.
        done_cyc.delete();
        for (int k = 0; k < 3; k++) exp_q.push_back(mk(7, 16, 3, -2));
        @(negedge clk);
        set_in(5, 7, 2, 9);
        start = 1'b1;
        e0 = cyc + 1;
        repeat (7) @(negedge clk);
        start = 1'b0;
        drain("held");
        repeat (4) @(negedge clk);
        check("held_count", W'(done_cyc.size()), W'(3));
        for (int k = 0; k < 3 && k < done_cyc.size(); k++)
            check($sformatf("held_lat%0d", k), W'(done_cyc[k]), W'(e0 + 1 + 3 * k));

        // Reset while in CALC aborts the operation.
        done_cyc.delete();
        pulse(1000, 2000, 3000, 4000);
        rst = 1'b1;
        #1;
        check("midrst_done", W'(done), '0);
        check_outs("midrst", mk(0, 0, 0, 0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_count", W'(done_cyc.size()), '0);
        exp_q.push_back(mk(-2, 0, 0, -2));
        pulse(-1, -1, -1, 1);
        drain("after_rst");
        check("after_rst_count", W'(done_cyc.size()), W'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
